partition_resp_monitor: RTL and testbench

//   Consumer end of the exhaustive partition sweep. Accepts one exact/approximate output pair per

---
 rtl/partition_mon_pkg.sv | 20 ++
 rtl/partition_resp_monitor_if.sv | 31 +++
 rtl/prm_misr.sv | 22 ++
 rtl/partition_resp_monitor.sv | 126 ++++++++++++
 tb/tb_partition_resp_monitor.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/partition_mon_pkg.sv
// Shared types and helpers for the partition response monitor.
// State encoding, default widths and the absolute-difference function.
package partition_mon_pkg;

    localparam int PI_W_DEF = 8;
    localparam int PO_W_DEF = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } prm_state_t;

    // Larger minus smaller, so the result never wraps.
    function automatic logic [15:0] abs_diff(input logic [15:0] a, input logic [15:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/partition_resp_monitor_if.sv
// Handshake and result bundle between the sweep driver (master) and the monitor (slave).
interface partition_resp_monitor_if #(
    parameter int PI_W  = 8,
    parameter int PO_W  = 5,
    parameter int CNT_W = PI_W + 1,
    parameter int SUM_W = PO_W + PI_W
);
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [PI_W-1:0]  pi_idx;
    logic [PO_W-1:0]  exact_po;
    logic [PO_W-1:0]  approx_po;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] err_cnt;
    logic [SUM_W-1:0] err_sum;
    logic [PO_W-1:0]  err_max;
    logic             seq_err;
    logic [PO_W-1:0]  signature;

    modport master (
        output start, in_valid, pi_idx, exact_po, approx_po,
        input  in_ready, busy, done, err_cnt, err_sum, err_max, seq_err, signature
    );

    modport slave (
        input  start, in_valid, pi_idx, exact_po, approx_po,
        output in_ready, busy, done, err_cnt, err_sum, err_max, seq_err, signature
    );
endinterface

// File: rtl/prm_misr.sv
// PO_W-bit MISR compacting the approximate outputs of one sweep.
module prm_misr #(
    parameter int PO_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            clr,
    input  logic [PO_W-1:0] din,
    output logic [PO_W-1:0] sig
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sig <= '0;
        else if (clr)
            sig <= '0;
        else if (en)
            sig <= {sig[PO_W-2:0], sig[PO_W-1] ^ sig[PO_W-2]} ^ din;
    end

endmodule

// File: rtl/partition_resp_monitor.sv
// Consumer end of the exhaustive partition sweep: in-order check plus error metrics.
// Optional approx_po signature MISR enabled by defining PRM_MISR_EN.
module partition_resp_monitor
    import partition_mon_pkg::*;
#(
    parameter int PI_W  = PI_W_DEF,
    parameter int PO_W  = PO_W_DEF,
    parameter int CNT_W = PI_W + 1,
    parameter int SUM_W = PO_W + PI_W
) (
    input  logic                   clk,
    input  logic                   rst,
    partition_resp_monitor_if.slave bus
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_RUN   = RUN;
    localparam logic [1:0] S_FLUSH = FLUSH;
    localparam logic [1:0] S_DONE  = DONE;

    logic [1:0]       state_q, state_d;
    logic [PI_W-1:0]  exp_idx_q;
    logic             seq_err_q;
    logic             v1_q, mism_q;
    logic [PO_W-1:0]  d_q, diff;
    logic [CNT_W-1:0] err_cnt_q;
    logic [SUM_W-1:0] err_sum_q;
    logic [PO_W-1:0]  err_max_q;

    logic accept, start_ok, last_idx;

    assign accept   = bus.in_valid && (state_q == S_RUN);
    assign start_ok = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign last_idx = (exp_idx_q == '1);
    assign diff     = PO_W'(abs_diff(16'(bus.exact_po), 16'(bus.approx_po)));

    // NOTE: default assignment first so every path drives state_d and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN:   if (accept && last_idx) state_d = S_FLUSH;
            S_FLUSH: state_d = S_DONE;
            S_DONE:  if (bus.start) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            exp_idx_q <= '0;
            seq_err_q <= 1'b0;
            v1_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            v1_q    <= accept;
            if (start_ok) begin
                exp_idx_q <= '0;
                seq_err_q <= 1'b0;
            end else if (accept) begin
                exp_idx_q <= exp_idx_q + 1'b1;
                if (bus.pi_idx != exp_idx_q)
                    seq_err_q <= 1'b1;
            end
        end
    end

    // NOTE: stage-1 data needs no reset; it is only consumed when v1_q, which is reset, is set.
    always_ff @(posedge clk) begin
        if (accept) begin
            d_q    <= diff;
            mism_q <= (diff != '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
            err_sum_q <= '0;
            err_max_q <= '0;
        end else if (start_ok) begin
            err_cnt_q <= '0;
            err_sum_q <= '0;
            err_max_q <= '0;
        end else if (v1_q) begin
            err_cnt_q <= err_cnt_q + CNT_W'(mism_q);
            err_sum_q <= err_sum_q + SUM_W'(d_q);
            if (d_q > err_max_q)
                err_max_q <= d_q;
        end
    end

`ifdef PRM_MISR_EN
    logic [PO_W-1:0] approx_q;
    logic [PO_W-1:0] sig;

    always_ff @(posedge clk) begin
        if (accept)
            approx_q <= bus.approx_po;
    end

    prm_misr #(.PO_W(PO_W)) u_misr (
        .clk (clk),
        .rst (rst),
        .en  (v1_q),
        .clr (start_ok),
        .din (approx_q),
        .sig (sig)
    );

    assign bus.signature = sig;
`else
    assign bus.signature = '0;
`endif

    assign bus.in_ready = (state_q == S_RUN);
    assign bus.busy     = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign bus.done     = (state_q == S_DONE);
    assign bus.err_cnt  = err_cnt_q;
    assign bus.err_sum  = err_sum_q;
    assign bus.err_max  = err_max_q;
    assign bus.seq_err  = seq_err_q;

endmodule

// File: tb/tb_partition_resp_monitor.sv
// Self-checking bench for partition_resp_monitor: per-sweep expected results are queued
// as stimulus is driven and compared when done rises.
module tb_partition_resp_monitor;

    localparam int PI_W  = 8;
    localparam int PO_W  = 5;
    localparam int CNT_W = PI_W + 1;
    localparam int SUM_W = PO_W + PI_W;
    localparam int N     = 1 << PI_W;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    partition_resp_monitor_if #(.PI_W(PI_W), .PO_W(PO_W), .CNT_W(CNT_W), .SUM_W(SUM_W)) bus ();

    partition_resp_monitor #(.PI_W(PI_W), .PO_W(PO_W), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [CNT_W-1:0] cnt;
        logic [SUM_W-1:0] sum;
        logic [PO_W-1:0]  mx;
        logic             seq;
        logic [PO_W-1:0]  sig;
    } res_t;

    res_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state for the sweep in progress.
    int        m_cnt, m_sum, m_max, m_exp_idx;
    logic      m_seq;
    logic [4:0] m_sig;

    task automatic model_clear();
        m_cnt = 0; m_sum = 0; m_max = 0; m_exp_idx = 0; m_seq = 1'b0; m_sig = '0;
    endtask

    task automatic model_pair(input int idx, input int ex, input int ap);
        int d;
        d = (ex > ap) ? ex - ap : ap - ex;
        if (d != 0) m_cnt++;
        m_sum += d;
        if (d > m_max) m_max = d;
        if (idx != m_exp_idx) m_seq = 1'b1;
        m_exp_idx = (m_exp_idx + 1) % N;
`ifdef PRM_MISR_EN
        m_sig = {m_sig[3:0], m_sig[4] ^ m_sig[3]} ^ 5'(ap);
`endif
    endtask

    task automatic push_expected();
        res_t r;
        r.cnt = CNT_W'(m_cnt);
        r.sum = SUM_W'(m_sum);
        r.mx  = PO_W'(m_max);
        r.seq = m_seq;
        r.sig = m_sig;
        exp_q.push_back(r);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void pattern(input int kind, input int i, output int idx, output int ex, output int ap);
        idx = i;
        ex  = (i * 7 + 3) % 32;
        ap  = ex;
        case (kind)
            2: ap = ex ^ 1;
            3: begin ex = (i == 37) ? 31 : i % 32; ap = (i == 37) ? 0 : ex; end
            4: begin if (i == 10) idx = 11; else if (i == 11) idx = 10; end
            6: begin ex = (i >> 3) % 32; ap = i % 32; end
            default: ;
        endcase
    endfunction

    task automatic pulse_start(output int s);
        bus.start = 1'b1;
        s = cyc;
        tick();
        bus.start = 1'b0;
    endtask

    // Present one pair and hold it until the monitor accepts it.
    task automatic send(input int idx, input int ex, input int ap, input bit gap);
        if (gap) begin
            bus.in_valid = 1'b0;
            tick();
        end
        bus.in_valid  = 1'b1;
        bus.pi_idx    = PI_W'(idx);
        bus.exact_po  = PO_W'(ex);
        bus.approx_po = PO_W'(ap);
        for (int w = 0; w < 20 && bus.in_ready !== 1'b1; w++) tick();
        if (bus.in_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL send_timeout idx=%0d: in_ready got %b want 1", idx, bus.in_ready);
        end
        model_pair(idx, ex, ap);
        tick();
    endtask

    task automatic wait_done(input int s, input int lat, input string name);
        res_t e;
        for (int w = 0; w < 600 && bus.done !== 1'b1; w++) tick();
        checks++;
        if (bus.done !== 1'b1) begin
            errors++;
            $display("FAIL %s done_timeout: done got %b want 1", name, bus.done);
        end else if (cyc - s != lat) begin
            errors++;
            $display("FAIL %s done_latency: got %0d want %0d", name, cyc - s, lat);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_in_done: got %b want 0", name, bus.busy);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard_empty: got 0 entries want 1", name);
            return;
        end
        e = exp_q.pop_front();
        checks++;
        if (bus.err_cnt !== e.cnt) begin
            errors++; $display("FAIL %s err_cnt: got %0d want %0d", name, bus.err_cnt, e.cnt);
        end
        checks++;
        if (bus.err_sum !== e.sum) begin
            errors++; $display("FAIL %s err_sum: got %0d want %0d", name, bus.err_sum, e.sum);
        end
        checks++;
        if (bus.err_max !== e.mx) begin
            errors++; $display("FAIL %s err_max: got %0d want %0d", name, bus.err_max, e.mx);
        end
        checks++;
        if (bus.seq_err !== e.seq) begin
            errors++; $display("FAIL %s seq_err: got %b want %b", name, bus.seq_err, e.seq);
        end
        checks++;
        if (bus.signature !== e.sig) begin
            errors++; $display("FAIL %s signature: got %h want %h", name, bus.signature, e.sig);
        end
    endtask

    task automatic run_sweep(input int kind, input bit gap, input int lat, input string name);
        int s, idx, ex, ap;
        model_clear();
        pulse_start(s);
        for (int i = 0; i < N; i++) begin
            pattern(kind, i, idx, ex, ap);
            if (kind == 2 && i == 128) bus.start = 1'b1;
            send(idx, ex, ap, gap);
            bus.start = 1'b0;
            if (kind == 2 && i == 128) begin
                checks++;
                if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL %s start_in_run: busy/in_ready got %b%b want 11", name, bus.busy, bus.in_ready);
                end
            end
            if (kind == 4 && (i == 9 || i == 10)) begin
                checks++;
                if (bus.seq_err !== (i == 10)) begin
                    errors++;
                    $display("FAIL %s seq_err_timing i=%0d: got %b want %b", name, i, bus.seq_err, i == 10);
                end
            end
        end
        bus.in_valid = 1'b0;
        push_expected();
        wait_done(s, lat, name);
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.pi_idx = '0; bus.exact_po = '0; bus.approx_po = '0;
        rst = 1'b1;
        tick(); tick();
        checks++;
        if ({bus.in_ready, bus.busy, bus.done, bus.seq_err} !== 4'b0000 ||
            bus.err_cnt !== '0 || bus.err_sum !== '0 || bus.err_max !== '0 || bus.signature !== '0) begin
            errors++;
            $display("FAIL reset_state: rdy/busy/done/seq=%b%b%b%b cnt=%0d sum=%0d max=%0d sig=%h want all 0",
                     bus.in_ready, bus.busy, bus.done, bus.seq_err, bus.err_cnt, bus.err_sum, bus.err_max, bus.signature);
        end
        rst = 1'b0;
        bus.in_valid = 1'b1; bus.exact_po = 5'd31; bus.approx_po = 5'd0;
        tick(); tick();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0 || bus.err_cnt !== '0) begin
            errors++;
            $display("FAIL idle_ignore: in_ready=%b busy=%b err_cnt=%0d want 0 0 0", bus.in_ready, bus.busy, bus.err_cnt);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_clean();
        run_sweep(1, 1'b0, 258, "clean");
    endtask

    task automatic test_back_to_back_lsb();
        run_sweep(2, 1'b0, 258, "lsb_flip");
        bus.in_valid = 1'b1; bus.pi_idx = '0; bus.exact_po = 5'd0; bus.approx_po = 5'd31;
        tick(); tick(); tick();
        checks++;
        if (bus.in_ready !== 1'b0 || bus.done !== 1'b1 || bus.err_cnt !== 9'd256 ||
            bus.err_sum !== 13'd256 || bus.err_max !== 5'd1) begin
            errors++;
            $display("FAIL done_hold: rdy=%b done=%b cnt=%0d sum=%0d max=%0d want 0 1 256 256 1",
                     bus.in_ready, bus.done, bus.err_cnt, bus.err_sum, bus.err_max);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_stall_single();
        run_sweep(3, 1'b1, 514, "stall_single");
    endtask

    task automatic test_swap();
        run_sweep(4, 1'b0, 258, "swap");
    endtask

    task automatic test_reset_mid();
        int s, idx, ex, ap;
        model_clear();
        pulse_start(s);
        for (int i = 0; i < 100; i++) begin
            pattern(2, i, idx, ex, ap);
            send(idx, ex, ap, 1'b0);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.in_ready, bus.busy, bus.done, bus.seq_err} !== 4'b0000 ||
            bus.err_cnt !== '0 || bus.err_sum !== '0 || bus.err_max !== '0 || bus.signature !== '0) begin
            errors++;
            $display("FAIL reset_mid: rdy/busy/done/seq=%b%b%b%b cnt=%0d sum=%0d max=%0d want all 0",
                     bus.in_ready, bus.busy, bus.done, bus.seq_err, bus.err_cnt, bus.err_sum, bus.err_max);
        end
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        run_sweep(1, 1'b0, 258, "after_reset");
    endtask

    task automatic test_misr();
        run_sweep(6, 1'b0, 258, "misr");
    endtask

    initial begin
        test_reset();
        test_clean();
        test_back_to_back_lsb();
        test_stall_single();
        test_swap();
        test_reset_mid();
        test_misr();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
